// File: rtl/dram_result_uart_streamer_if.sv
// Byte-strobe link between the result streamer and the UART transmitter.
// Master drives the byte and strobe; slave reports transmitter busy.
interface dram_result_uart_streamer_if;
  logic       uart_en;
  logic [7:0] uart_din;
  logic       uart_busy;

  modport master (
    output uart_en,
    output uart_din,
    input  uart_busy
  );

  modport slave (
    input  uart_en,
    input  uart_din,
    output uart_busy
  );
endinterface

// File: rtl/dram_result_uart_streamer.sv
// Snapshots a multi-channel DRAM readback vector on trigger and streams it
// as a framed raw or ASCII-hex byte sequence through uart_send.
module dram_result_uart_streamer #(
  parameter int         NUM_CH       = 16,
  parameter int         DATA_W       = 8,
  parameter logic [7:0] SEP_BYTE     = 8'h0A,
  parameter logic [7:0] HDR_BYTE     = 8'hA5,
  parameter bit         HDR_EN       = 1'b1,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic                     clk_100m,
  input  logic                     rst_n,
  input  logic                     trig,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     mode_hex,
  input  logic                     sep_en,
  dram_result_uart_streamer_if.master uart,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = $clog2(DATA_W / 4);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] RAW_LAST = IDX_W'(DATA_W / 8 - 1);
  localparam logic [IDX_W-1:0] HEX_LAST = IDX_W'(DATA_W / 4 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_PAY,
    PH_SEP
  } phase_t;

  state_t state_q;
  state_t state_n;
  phase_t ph_q;

  logic [NUM_CH-1:0][DATA_W-1:0] snap_q;
  logic             hex_q;
  logic             sep_q;
  logic             trig_d;
  logic             ovr_q;
  logic             tmo_err_q;
  logic [CH_W-1:0]  ch_q;
  logic [IDX_W-1:0] idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       din_q;

  logic              trig_rise;
  logic              start;
  logic              adv;
  logic              strobe;
  logic              tmo_hit;
  logic              tmo_inc;
  logic              pay_last;
  logic              ch_last;
  logic              last_byte;
  logic [DATA_W-1:0] word;
  logic [7:0]        raw_byte;
  logic [3:0]        nib;
  logic [7:0]        hex_chr;
  logic [7:0]        cur_byte;

  assign trig_rise = trig & ~trig_d;

  // Byte currently addressed by phase/channel/index counters.
  always_comb begin
    word     = snap_q[ch_q];
    raw_byte = 8'(word >> {RAW_LAST - idx_q, 3'b000});
    nib      = 4'(word >> {HEX_LAST - idx_q, 2'b00});
    if (nib < 4'd10) begin
      hex_chr = 8'h30 + {4'h0, nib};
    end else begin
      hex_chr = 8'h37 + {4'h0, nib};
    end
    unique case (ph_q)
      PH_HDR:  cur_byte = HDR_BYTE;
      PH_SEP:  cur_byte = SEP_BYTE;
      default: cur_byte = hex_q ? hex_chr : raw_byte;
    endcase
  end

  // Position flags: end of a channel payload and end of the whole frame.
  always_comb begin
    pay_last  = (idx_q == (hex_q ? HEX_LAST : RAW_LAST));
    ch_last   = (ch_q == CH_LAST);
    last_byte = ch_last &&
                ((ph_q == PH_SEP) ||
                 ((ph_q == PH_PAY) && pay_last && !sep_q));
  end

  // State register.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and strobe decode; strobe only ever fires from ISSUE.
  always_comb begin
    state_n = state_q;
    strobe  = 1'b0;
    start   = 1'b0;
    adv     = 1'b0;
    tmo_hit = 1'b0;
    tmo_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          start   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!uart.uart_busy) begin
          strobe  = 1'b1;
          state_n = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (uart.uart_busy) begin
          state_n = S_WAIT_LO;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          adv     = 1'b1;
          state_n = last_byte ? S_DONE : S_ISSUE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!uart.uart_busy) begin
          adv     = 1'b1;
          state_n = last_byte ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Trigger edge history and snapshot capture on an accepted trigger.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      trig_d <= 1'b0;
      snap_q <= '0;
      hex_q  <= 1'b0;
      sep_q  <= 1'b0;
    end else begin
      trig_d <= trig;
      if (start) begin
        snap_q <= data_in;
        hex_q  <= mode_hex;
        sep_q  <= sep_en;
      end
    end
  end

  // Frame walk: header, then per channel payload and optional separator.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= PH_HDR;
      ch_q  <= '0;
      idx_q <= '0;
    end else if (start) begin
      ph_q  <= HDR_EN ? PH_HDR : PH_PAY;
      ch_q  <= '0;
      idx_q <= '0;
    end else if (adv && !last_byte) begin
      unique case (ph_q)
        PH_HDR: begin
          ph_q  <= PH_PAY;
          idx_q <= '0;
        end
        PH_PAY: begin
          if (pay_last) begin
            idx_q <= '0;
            if (sep_q) begin
              ph_q <= PH_SEP;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          ph_q <= PH_PAY;
          ch_q <= ch_q + 1'b1;
        end
      endcase
    end
  end

  // Busy-rise timeout counter, restarted at every strobe.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (strobe) begin
      tmo_q <= '0;
    end else if (tmo_inc) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Last strobed byte, held on uart_din between strobes.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= '0;
    end else if (strobe) begin
      din_q <= cur_byte;
    end
  end

  // Sticky error flags, cleared when a new frame is accepted.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else if (start) begin
      ovr_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      if (trig_rise && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign uart.uart_en  = strobe;
  assign uart.uart_din = strobe ? cur_byte : din_q;

  assign busy        = (state_q == S_ISSUE) ||
                       (state_q == S_WAIT_HI) ||
                       (state_q == S_WAIT_LO);
  assign done        = (state_q == S_DONE);
  assign overrun     = ovr_q;
  assign timeout_err = tmo_err_q;

endmodule
